// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues sequential ROM fetches and buffers
// {pc, inst} pairs for decode under a valid/allow_in handshake.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   br_taken/br_target  redirect request and address (bits [1:0] ignored)
//   hold_flag_if        blocks new ROM requests only
//   irom_adr/irom_en    ROM request; data returns on irom_inst next cycle
//   irom_inst           ROM read data
//   id_allow_in         decode accepts the head entry this cycle
//   pf_to_id_*          head entry valid/pc/inst
//   pf_count            occupied entries
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         br_taken,
    input  logic [31:0]                  br_target,
    input  logic                         hold_flag_if,
    output logic [31:0]                  irom_adr,
    output logic                         irom_en,
    input  logic [31:0]                  irom_inst,
    input  logic                         id_allow_in,
    output logic                         pf_to_id_valid,
    output logic [31:0]                  pf_to_id_pc,
    output logic [31:0]                  pf_to_id_inst,
    output logic [$clog2(DEPTH+1)-1:0]   pf_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;
    logic          r_kill;
    logic          r_started;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc_q   [DEPTH];
    logic [31:0]   r_inst_q [DEPTH];

    logic [CW:0]   w_occ;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;

    // Entries held plus the one response still on its way; issuing only
    // below DEPTH means a returning word always has a free slot.
    assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = r_started & ~br_taken & ~hold_flag_if
                   & (w_occ < (CW+1)'(DEPTH));
    assign w_push  = r_inflight & ~r_kill & ~br_taken;
    assign w_pop   = pf_to_id_valid & id_allow_in & ~br_taken;

    assign irom_en        = w_issue;
    assign irom_adr       = r_fetch_pc;
    assign pf_to_id_valid = (r_count != '0);
    assign pf_to_id_pc    = r_pc_q[r_rd_ptr];
    assign pf_to_id_inst  = r_inst_q[r_rd_ptr];
    assign pf_count       = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
            r_started  <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pc_q[i]   <= '0;
                r_inst_q[i] <= '0;
            end
        end else begin
            r_started <= 1'b1;
            // A response to a pre-redirect request must not be queued.
            r_kill    <= br_taken & r_inflight;
            if (br_taken) begin
                r_fetch_pc <= {br_target[31:2], 2'b00};
                r_inflight <= 1'b0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_req_pc   <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_pc_q[r_wr_ptr]   <= r_req_pc;
                    r_inst_q[r_wr_ptr] <= irom_inst;
                    r_wr_ptr           <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

endmodule
